// File: rtl/bloco_operativo_pkg.sv
// bloco_operativo_pkg: mux select and ALU op encodings shared by the datapath and control FSM
package bloco_operativo_pkg;
    // Operand A source (m0)
    typedef enum logic [1:0] {M0_COEF_A = 2'd0, M0_H = 2'd1, M0_X = 2'd2, M0_ZERO = 2'd3} m0_sel_e;
    // Operand B source (m1)
    typedef enum logic [1:0] {M1_X = 2'd0, M1_COEF_B = 2'd1, M1_COEF_C = 2'd2, M1_ZERO = 2'd3} m1_sel_e;
    // H write source (m2)
    typedef enum logic [1:0] {M2_ALU = 2'd0, M2_X_IN = 2'd1, M2_COEF_C = 2'd2, M2_ZERO = 2'd3} m2_sel_e;
    // ALU operation (h)
    typedef enum logic {OP_ADD = 1'b0, OP_MUL = 1'b1} op_e;
endpackage

// File: rtl/bloco_operativo_ula.sv
// ula_operativa: combinational multiply/add with overflow flag
//   a_i, b_i : operands
//   op_i     : 1 = multiply, 0 = add
//   y_o      : low WIDTH bits of the result, clamped to all-ones on overflow
//              when BLOCO_OPERATIVO_SAT_EN is defined, wrapped otherwise
//   ovf_o    : product high half non-zero or sum carry-out
module ula_operativa
    import bloco_operativo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    output logic [WIDTH-1:0] y_o,
    output logic             ovf_o
);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   raw;

    always_comb begin
        prod  = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        sum   = {1'b0, a_i} + {1'b0, b_i};
        ovf_o = (op_i == OP_MUL) ? |prod[2*WIDTH-1:WIDTH] : sum[WIDTH];
        raw   = (op_i == OP_MUL) ? prod[WIDTH-1:0] : sum[WIDTH-1:0];
`ifdef BLOCO_OPERATIVO_SAT_EN
        y_o   = ovf_o ? '1 : raw;
`else
        y_o   = raw;
`endif
    end
endmodule

// File: rtl/bloco_operativo.sv
// bloco_operativo: Horner datapath for y = A*X^2 + B*X + C driven by external control strobes
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   x_in, coef_a/b/c       : operand X and coefficients
//   h                      : ALU op (1 multiply, 0 add)
//   Reg_X, Reg_H, Reg_S    : load strobes for X, H and S
//   m0, m1, m2             : operand A, operand B and H source selects
//   result, result_valid   : S register and completed-evaluation flag
//   overflow               : sticky overflow for the current evaluation
//   Optional BLOCO_OPERATIVO_SAT_EN: saturate overflowing ALU results written to H
module bloco_operativo
    import bloco_operativo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] coef_a,
    input  logic [WIDTH-1:0] coef_b,
    input  logic [WIDTH-1:0] coef_c,
    input  logic             h,
    input  logic             Reg_X,
    input  logic             Reg_H,
    input  logic             Reg_S,
    input  logic [1:0]       m0,
    input  logic [1:0]       m1,
    input  logic [1:0]       m2,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overflow
);
    logic [WIDTH-1:0] x_q, x_d, h_q, h_d, s_q, s_d, op_a, op_b, alu_y;
    logic             valid_q, valid_d, ovf_q, ovf_d, alu_ovf, ovf_evt;

    ula_operativa #(.WIDTH(WIDTH)) u_ula (
        .a_i  (op_a),
        .b_i  (op_b),
        .op_i (h),
        .y_o  (alu_y),
        .ovf_o(alu_ovf)
    );

    always_comb begin
        op_a    = (m0 == M0_COEF_A) ? coef_a : (m0 == M0_H) ? h_q : (m0 == M0_X) ? x_q : '0;
        op_b    = (m1 == M1_X) ? x_q : (m1 == M1_COEF_B) ? coef_b : (m1 == M1_COEF_C) ? coef_c : '0;
        // Only ALU results actually written into H count as overflow events
        ovf_evt = Reg_H && (m2 == M2_ALU) && alu_ovf;
        x_d     = Reg_X ? x_in : x_q;
        h_d     = !Reg_H ? h_q : (m2 == M2_ALU) ? alu_y : (m2 == M2_X_IN) ? x_in :
                  (m2 == M2_COEF_C) ? coef_c : '0;
        s_d     = Reg_S ? h_q : s_q;
        valid_d = Reg_S ? 1'b1 : Reg_X ? 1'b0 : valid_q;
        // A new event in the Reg_X cycle wins over the start-of-evaluation clear
        ovf_d   = ovf_evt ? 1'b1 : Reg_X ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q     <= '0;
            h_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            h_q     <= h_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign result       = s_q;
    assign result_valid = valid_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_bloco_operativo.sv
// tb_bloco_operativo: scoreboard bench for the Horner datapath
module tb_bloco_operativo;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] x_in, coef_a, coef_b, coef_c;
    logic         h, Reg_X, Reg_H, Reg_S;
    logic [1:0]   m0, m1, m2;
    logic [W-1:0] result;
    logic         result_valid, overflow;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         v;
        logic         o;
    } exp_t;
    exp_t sb[$];

    logic [W-1:0] mx, mh, ms;
    logic         mv, mo;

    bloco_operativo #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .x_in        (x_in),
        .coef_a      (coef_a),
        .coef_b      (coef_b),
        .coef_c      (coef_c),
        .h           (h),
        .Reg_X       (Reg_X),
        .Reg_H       (Reg_H),
        .Reg_S       (Reg_S),
        .m0          (m0),
        .m1          (m1),
        .m2          (m2),
        .result      (result),
        .result_valid(result_valid),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: reference model predicts, scoreboard compares after the edge
    task automatic step(input logic rx, input logic rh, input logic rs, input logic [1:0] as,
                        input logic [1:0] bs, input logic [1:0] src, input logic op,
                        input logic [W-1:0] xi, input logic rst = 1'b0);
        logic [W-1:0]   a, b, alu, hn;
        logic [2*W-1:0] full;
        logic           ev;
        exp_t           e;
        a    = (as == 0) ? coef_a : (as == 1) ? mh : (as == 2) ? mx : '0;
        b    = (bs == 0) ? mx : (bs == 1) ? coef_b : (bs == 2) ? coef_c : '0;
        full = op ? {{W{1'b0}}, a} * {{W{1'b0}}, b} : {{W{1'b0}}, a} + {{W{1'b0}}, b};
        ev   = op ? |full[2*W-1:W] : full[W];
        alu  = full[W-1:0];
`ifdef BLOCO_OPERATIVO_SAT_EN
        if (ev) alu = '1;
`endif
        hn = (src == 0) ? alu : (src == 1) ? xi : (src == 2) ? coef_c : '0;
        if (rst) begin
            mx = '0; mh = '0; ms = '0; mv = 1'b0; mo = 1'b0;
        end else begin
            mo = (rh && src == 0 && ev) ? 1'b1 : rx ? 1'b0 : mo;
            mv = rs ? 1'b1 : rx ? 1'b0 : mv;
            if (rs) ms = mh;
            if (rh) mh = hn;
            if (rx) mx = xi;
        end
        e.r = ms; e.v = mv; e.o = mo;
        sb.push_back(e);
        reset = rst; Reg_X = rx; Reg_H = rh; Reg_S = rs;
        m0 = as; m1 = bs; m2 = src; h = op; x_in = xi;
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("sb_result", result, e.r);
        check("sb_valid", result_valid, e.v);
        check("sb_ovf", overflow, e.o);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] x);
        coef_a = a; coef_b = b; coef_c = c;
        step(1, 0, 0, 0, 0, 0, 0, x);
        step(0, 1, 0, 0, 0, 0, 1, x);
        step(0, 1, 0, 1, 1, 0, 0, x);
        step(0, 1, 0, 1, 0, 0, 1, x);
        step(0, 1, 0, 1, 2, 0, 0, x);
        check("lat_valid_pre", result_valid, 0);
        step(0, 0, 1, 0, 0, 0, 0, x);
    endtask

    logic [W-1:0] sat_or_zero;

    initial begin
        sat_or_zero = '0;
`ifdef BLOCO_OPERATIVO_SAT_EN
        sat_or_zero = '1;
`endif
        coef_a = '0; coef_b = '0; coef_c = '0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 1, 0, 16'h1234, 1);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_ovf", overflow, 0);

        run(2, 3, 5, 4);
        check("nominal_result", result, 49);
        check("nominal_valid", result_valid, 1);
        check("nominal_ovf", overflow, 0);

        step(0, 0, 0, 3, 3, 3, 0, 16'hBEEF);
        check("idle_hold", result, 49);
        step(1, 0, 0, 3, 3, 3, 0, 9);
        check("regx_valid_drop", result_valid, 0);
        check("regx_result_hold", result, 49);

        run(16'h0100, 0, 0, 16'h0100);
        check("mulwrap_result", result, sat_or_zero);
        check("mulwrap_ovf", overflow, 1);

        run(0, 0, 16'hFFFF, 1);
        check("carry_pre_ovf", overflow, 0);
        step(0, 1, 0, 0, 0, 1, 0, 1);
        step(0, 1, 0, 1, 2, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 1);
        check("carry_result", result, sat_or_zero);
        check("carry_ovf", overflow, 1);

        coef_a = 2;
        step(1, 0, 0, 0, 0, 0, 0, 3);
        step(1, 1, 0, 0, 0, 0, 1, 7);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("simul_h_old_x", result, 6);
        step(0, 1, 0, 2, 3, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("simul_x_new", result, 7);

        coef_b = 1;
        step(0, 1, 0, 0, 0, 1, 0, 16'hFFFF);
        step(1, 1, 0, 1, 1, 0, 0, 5);
        check("regx_ovf_priority", overflow, 1);

        coef_a = 2; coef_b = 3; coef_c = 5;
        step(1, 0, 0, 0, 0, 0, 0, 4);
        step(0, 1, 0, 0, 0, 0, 1, 4);
        step(0, 1, 0, 1, 1, 0, 0, 4);
        step(0, 1, 1, 1, 0, 0, 1, 4, 1);
        check("midrst_result", result, 0);
        check("midrst_valid", result_valid, 0);
        check("midrst_ovf", overflow, 0);
        run(1, 1, 1, 1);
        check("fresh_result", result, 3);
        check("fresh_ovf", overflow, 0);

        for (int i = 0; i < 40; i++) begin
            coef_a = W'($urandom); coef_b = W'($urandom); coef_c = W'($urandom);
            step(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                 2'($urandom), 1'($urandom), W'($urandom), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 4; i++)
            run(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bloco_operativo.md
# bloco_operativo

Datapath stage driven directly by the control FSM. Evaluates the quadratic y = A·X² + B·X + C by Horner's rule: X, accumulator H and result S registers, one shared multiply/add unit and three operand/source muxes. Executes only what the control strobes request each cycle; it holds no sequencing state of its own beyond result/overflow status. Result and status are exported to the output interface.

## Interface
Parameters:
- WIDTH, 16, data width of inputs, registers and result (unsigned).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- x_in  in  WIDTH  operand X, sampled when Reg_X=1.
- coef_a, coef_b, coef_c  in  WIDTH each  coefficients; must be stable from Reg_X until Reg_S.
- h  in  1  ALU op: 1 = multiply, 0 = add.
- Reg_X  in  1  load X register from x_in.
- Reg_H  in  1  load H register from the m2-selected source.
- Reg_S  in  1  load S register from H.
- m0  in  2  ALU operand A select.
- m1  in  2  ALU operand B select.
- m2  in  2  H write-source select.
- result  out  WIDTH  S register.
- result_valid  out  1  S holds a completed evaluation.
- overflow  out  1  sticky arithmetic overflow for the current evaluation.

## Operation
- Operand A (m0): 0 = coef_a, 1 = H, 2 = X, 3 = 0.
- Operand B (m1): 0 = X, 1 = coef_b, 2 = coef_c, 3 = 0.
- H source (m2): 0 = ALU result, 1 = x_in, 2 = coef_c, 3 = 0.
- ALU is combinational. Multiply: full 2·WIDTH product, low WIDTH bits kept; overflow event if any high bit is set. Add: WIDTH+1 sum, low WIDTH bits kept; overflow event on carry-out.
- An overflow event is counted only when Reg_H=1 and m2=0.
- Reference Horner sequence, one cycle per step:
  1. Reg_X.
  2. m0=0, m1=0, h=1, m2=0, Reg_H (H = A·X).
  3. m0=1, m1=1, h=0, Reg_H (H += B).
  4. m0=1, m1=0, h=1, Reg_H (H ·= X).
  5. m0=1, m1=2, h=0, Reg_H (H += C).
  6. Reg_S.
- Reg_X clears result_valid and overflow in the same edge, which starts a new evaluation.
- Reg_S sets result_valid at that edge; it stays set until the next Reg_X or reset.
- overflow sets on any counted overflow event and clears only on Reg_X or reset.

## Timing
- Reset: X=0, H=0, S=0, result=0, result_valid=0, overflow=0. Reset overrides all strobes in the same cycle.
- Every register updates at the clock edge on which its strobe is high. Values are visible the next cycle.
- Latency through the reference sequence: 6 cycles from Reg_X to result_valid=1.
- Reg_X and Reg_H in the same cycle: the ALU uses the old X.
- Reg_H and Reg_S in the same cycle: S takes the old H.
- Reg_X and a counted overflow in the same cycle: overflow ends at 1, because the set has priority over the clear.
- Reg_S without a preceding Reg_X: S loads H and result_valid=1 regardless.
- Strobes all low: every register holds.
- Reset asserted mid-sequence: all state returns to reset values on that edge. A partial H is discarded.

## Configuration
- BLOCO_OPERATIVO_SAT_EN defined: any overflowing ALU result written to H is clamped to all-ones (2^WIDTH−1). overflow behaves as above.
- BLOCO_OPERATIVO_SAT_EN undefined: results wrap modulo 2^WIDTH. overflow still flags.

## Structure
- Shared package holds the m0/m1/m2 select encodings and the h op encoding as named constants, shared with the control FSM.
- One sub-module, ula_operativa: combinational multiply/add with an overflow output and the saturation option. Muxes and registers stay in bloco_operativo.

## Test plan
- Nominal run (WIDTH=16): A=2, B=3, C=5, X=4, reference sequence → result=49, result_valid=1 at cycle 6, overflow=0.
- Multiply wrap: A=0x0100, B=0, C=0, X=0x0100 → overflow=1. Without SAT_EN result=0x0000; with SAT_EN result=0xFFFF.
- Add carry: A=0, B=0, C=0xFFFF, X=1; step 5 adds 0xFFFF to H=0 and then repeats with H=1 → overflow=1, result=0x0000 (wrap) or 0xFFFF (saturated).
- Simultaneous Reg_X and Reg_H with old X=3, new x_in=7, m0=0, m1=0, h=1, A=2 → H=6, X=7.
- Reset at step 4 of a run, followed by a fresh run with X=1, A=B=C=1 → all outputs 0 after reset, then result=3, overflow=0.
- Reg_X after a completed run → result_valid drops the next cycle, result keeps its old value until Reg_S.
